// File: rtl/hit_check_arbiter.sv
// hit_check_arbiter: round-robin sequencer for the shared single-bit hit-test unit (hit = A & B)
// Ports: clk, rst_n (sync active-low); req/op_a/op_b [NUM_REQ] per-requester inputs;
//        grant/done [NUM_REQ] one-hot outputs; hit (valid with done); busy (state != IDLE);
//        hit_count [15:0] saturating hit counter, present only with HIT_COUNT_EN defined.
module hit_check_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] op_a,
    input  logic [NUM_REQ-1:0] op_b,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               hit,
    output logic               busy
`ifdef HIT_COUNT_EN
    ,
    output logic [15:0]        hit_count
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RESULT = 2'd2} state_t;
    state_t               r_state, w_state_nx;
    logic [PTR_W-1:0]     r_ptr, w_ptr_nx, r_win, w_win_nx, w_sel;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nx, r_done, w_done_nx, w_rot;
    logic                 r_hit, w_hit_nx, w_found;
    // rotate so bit 0 of w_rot is requester ptr+1; the lowest set bit is the winner
    always_comb begin
        w_rot   = NUM_REQ'({req, req} >> (int'(r_ptr) + 1));
        w_sel   = '0;
        w_found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sel   = PTR_W'((int'(r_ptr) + 1 + j) % NUM_REQ);
            end
        end
    end
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_win_nx   = r_win;
        w_grant_nx = r_grant;
        w_done_nx  = '0;
        w_hit_nx   = 1'b0;
        case (r_state)
            IDLE: if (w_found) begin
                w_win_nx   = w_sel;
                w_grant_nx = NUM_REQ'(1) << w_sel;
                w_state_nx = GRANT;
            end
            GRANT: begin
                w_hit_nx   = |(op_a & op_b & r_grant);
                w_done_nx  = r_grant;
                w_grant_nx = '0;
                w_ptr_nx   = r_win;
                w_state_nx = RESULT;
            end
            default: w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= PTR_W'(NUM_REQ - 1);
            r_win   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_win   <= w_win_nx;
            r_grant <= w_grant_nx;
            r_done  <= w_done_nx;
            r_hit   <= w_hit_nx;
        end
    end
    assign grant = r_grant;
    assign done  = r_done;
    assign hit   = r_hit;
    assign busy  = r_state != IDLE;
`ifdef HIT_COUNT_EN
    logic [15:0] r_hit_count;
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_hit_count <= '0;
        else if (r_state == GRANT && w_hit_nx && r_hit_count != 16'hFFFF)
            r_hit_count <= r_hit_count + 16'd1;
    end
    assign hit_count = r_hit_count;
`endif
endmodule
